i2c_master: RTL and testbench
=============================

I2C_MASTER -- requirements
Module: i2c_master

Interface
REQ-001 Parameter CLK_DIV, default 2: clk cycles per SCL quarter-period; one bit period = 4*CLK_DIV clk cycles; legal range 1-255.
REQ-002 clk  input  1  system clock; all state on rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 rw  input  1  transaction type: 0 = write, 1 = read.
REQ-005 devAddr  input  7  I2C slave address.
REQ-006 devInnerAddr  input  8  slave register address.
REQ-007 sendData  input  8  write payload.
REQ-008 readData  output  8  byte received in a read transaction.
REQ-009 done  output  1  transaction complete flag.
REQ-010 scl  output  1  I2C clock, driven push-pull.
REQ-011 sda  inout  1  I2C data, open-drain: drives 0 or releases to high-Z; never drives 1.

Function
REQ-012 Exactly one transaction SHALL start automatically on the first rising clk edge with rst low.
- On that edge, rw, devAddr, devInnerAddr and sendData are latched.
- Later input changes are ignored until the next reset.
REQ-013 Bit timing SHALL use four quarter phases per bit:
- SCL low for quarters 0-1, high for quarters 2-3.
- SDA changes only at the start of quarter 0.
- Slave data/ACK is sampled at the end of quarter 2.
REQ-014 START: SDA falls while SCL is high, then SCL falls.
REQ-015 STOP: SDA low, SCL rises, then SDA is released while SCL is high.
REQ-016 Repeated START: SDA released, SCL rises, then SDA falls while SCL is high.
REQ-017 Write sequence SHALL be START, {devAddr,0}, ACK, devInnerAddr, ACK, sendData, ACK, STOP.
- Bytes are sent MSB first.
- Total length is 29 bit periods.
REQ-018 Read sequence SHALL be START, {devAddr,0}, ACK, devInnerAddr, ACK, repeated START, {devAddr,1}, ACK, 8 data bits, master NACK, STOP.
- During the 8 data bits, SDA is released.
- For the master NACK, SDA is released.
- Total length is 39 bit periods.
REQ-019 During every ACK slot the master SHALL release SDA.
REQ-020 Data bits SHALL be shifted into readData MSB first; readData updates only at the end of the 8th data bit.
REQ-021 On the clk edge ending the STOP period, done SHALL go high; it SHALL stay high, with SCL=1 and SDA released, until rst is asserted.
REQ-022 The state machine SHALL have these states: IDLE, START, SEND_BYTE, WAIT_ACK, RESTART, READ_BYTE, SEND_NACK, STOP, DONE.
- IDLE is held only while rst is high.
REQ-023 In a write transaction, readData SHALL remain 8'h00.

Reset
REQ-024 While rst is high, the outputs SHALL be held as follows:
- scl = 1
- sda released
- done = 0
- readData = 8'h00
- state = IDLE
- the bit and phase counters are cleared
REQ-025 Asserting rst mid-transaction SHALL abort immediately with no STOP generated.
- The transaction restarts from REQ-012 once rst is released.

Configuration
REQ-026 Macro I2C_MASTER_ACK_CHECK_EN controls slave ACK checking.
- Defined: a high SDA sampled in any slave-ACK slot aborts the transaction; the master issues STOP in the next bit period, sets done, and sets readData = 8'hFF.
- Undefined: ACK slots are clocked but not checked, and the transaction always runs to completion.

Verification
REQ-027 Hold rst high for 100 cycles -> scl=1, sda=Z, done=0, readData=8'h00 throughout.
REQ-028 Write, rw=0, devAddr=7'h40, devInnerAddr=8'h01, sendData=8'hBA, slave always ACKs -> bytes 8'h80, 8'h01, 8'hBA appear between START and STOP; done rises 29*4*CLK_DIV cycles after reset release.
REQ-029 Read, rw=1, devAddr=7'h40, devInnerAddr=8'h01, slave returns 8'h5A -> bytes 8'h80, 8'h01, repeated START, 8'h81; master NACKs, then STOP; readData=8'h5A and done=1 after 39 bit periods.
REQ-030 Assert rst during the second byte of a write -> scl=1, sda=Z and done=0 immediately; after release, the full write restarts from START.
REQ-031 With I2C_MASTER_ACK_CHECK_EN defined, slave NACKs the address byte -> STOP follows in the next bit period, done=1, readData=8'hFF; without the macro, the same stimulus completes the full 29-period write.
REQ-032 Change sendData mid-write -> the transmitted data byte equals the value latched at reset release.

Source files
------------

// File: rtl/i2c_master.sv
// I2C master that runs exactly one register write or register read after each reset release.
// Optional macro I2C_MASTER_ACK_CHECK_EN: a slave NACK aborts with STOP and readData = 8'hFF.
module i2c_master #(
    parameter int CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rw,
    input  logic [6:0] devAddr,
    input  logic [7:0] devInnerAddr,
    input  logic [7:0] sendData,
    output logic [7:0] readData,
    output logic       done,
    output logic       scl,
    inout  wire        sda
);
`ifdef I2C_MASTER_ACK_CHECK_EN
    localparam bit ACK_CHECK = 1'b1;
`else
    localparam bit ACK_CHECK = 1'b0;
`endif
    localparam logic [7:0] DIV_MAX = 8'(CLK_DIV - 1);

    typedef enum logic [3:0] {
        IDLE, START, SEND_BYTE, WAIT_ACK, RESTART, READ_BYTE, SEND_NACK, STOP, DONE
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  div_q, div_d;
    logic [1:0]  quarter_q, quarter_d;
    logic [2:0]  bit_q, bit_d;
    logic [1:0]  byte_q, byte_d;
    logic [7:0]  tx_q, tx_d, rx_q, rx_d, rdata_q, rdata_d;
    logic        done_q, done_d, ack_q, ack_d;
    logic        rw_q, rw_d;
    logic [6:0]  addr_q, addr_d;
    logic [7:0]  reg_q, reg_d, data_q, data_d;
    logic        scl_q, scl_d, sda_oe_q, sda_oe_d;
    logic        tick;

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        quarter_d = quarter_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        rdata_d   = rdata_q;
        done_d    = done_q;
        ack_d     = ack_q;
        rw_d      = rw_q;
        addr_d    = addr_q;
        reg_d     = reg_q;
        data_d    = data_q;
        tick      = (div_q == DIV_MAX);

        if (state_q == IDLE) begin
            // First edge out of reset: capture the whole transaction request.
            state_d   = START;
            div_d     = '0;
            quarter_d = '0;
            bit_d     = '0;
            byte_d    = '0;
            rw_d      = rw;
            addr_d    = devAddr;
            reg_d     = devInnerAddr;
            data_d    = sendData;
        end else if (state_q != DONE && !tick) begin
            div_d = div_q + 8'd1;
        end else if (state_q != DONE) begin
            div_d     = '0;
            quarter_d = quarter_q + 2'd1;
            if (quarter_q == 2'd2 && state_q == READ_BYTE) rx_d = {rx_q[6:0], sda};
            if (quarter_q == 2'd2 && state_q == WAIT_ACK)  ack_d = sda;
            if (quarter_q == 2'd3) begin
                case (state_q)
                    START: begin
                        state_d = SEND_BYTE;
                        tx_d    = {addr_q, 1'b0};
                        byte_d  = 2'd0;
                    end
                    SEND_BYTE: begin
                        tx_d  = {tx_q[6:0], 1'b0};
                        bit_d = bit_q + 3'd1;
                        if (bit_q == 3'd7) state_d = WAIT_ACK;
                    end
                    WAIT_ACK: begin
                        if (ACK_CHECK && ack_q) begin
                            state_d = STOP;
                            rdata_d = 8'hFF;
                        end else if (byte_q == 2'd0) begin
                            state_d = SEND_BYTE;
                            tx_d    = reg_q;
                            byte_d  = 2'd1;
                        end else if (byte_q == 2'd1 && rw_q) begin
                            state_d = RESTART;
                        end else if (byte_q == 2'd1) begin
                            state_d = SEND_BYTE;
                            tx_d    = data_q;
                            byte_d  = 2'd2;
                        end else begin
                            state_d = rw_q ? READ_BYTE : STOP;
                        end
                    end
                    RESTART: begin
                        state_d = SEND_BYTE;
                        tx_d    = {addr_q, 1'b1};
                        byte_d  = 2'd2;
                    end
                    READ_BYTE: begin
                        bit_d = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            state_d = SEND_NACK;
                            rdata_d = rx_q;
                        end
                    end
                    SEND_NACK: state_d = STOP;
                    STOP: begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                    default: state_d = state_q;
                endcase
            end
        end

        // Bus pins are decoded from the next state so they leave the flops cleanly.
        scl_d    = 1'b1;
        sda_oe_d = 1'b0;
        case (state_d)
            START: begin
                scl_d    = (quarter_d != 2'd3);
                sda_oe_d = (quarter_d != 2'd0);
            end
            STOP: begin
                scl_d    = quarter_d[1];
                sda_oe_d = (quarter_d != 2'd3);
            end
            RESTART: begin
                scl_d    = quarter_d[1];
                sda_oe_d = (quarter_d == 2'd3);
            end
            SEND_BYTE: begin
                scl_d    = quarter_d[1];
                sda_oe_d = ~tx_d[7];
            end
            WAIT_ACK, READ_BYTE, SEND_NACK: scl_d = quarter_d[1];
            default: scl_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            div_q     <= '0;
            quarter_q <= '0;
            bit_q     <= '0;
            byte_q    <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            rdata_q   <= '0;
            done_q    <= 1'b0;
            ack_q     <= 1'b0;
            rw_q      <= 1'b0;
            addr_q    <= '0;
            reg_q     <= '0;
            data_q    <= '0;
            scl_q     <= 1'b1;
            sda_oe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            quarter_q <= quarter_d;
            bit_q     <= bit_d;
            byte_q    <= byte_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            rdata_q   <= rdata_d;
            done_q    <= done_d;
            ack_q     <= ack_d;
            rw_q      <= rw_d;
            addr_q    <= addr_d;
            reg_q     <= reg_d;
            data_q    <= data_d;
            scl_q     <= scl_d;
            sda_oe_q  <= sda_oe_d;
        end
    end

    assign sda      = sda_oe_q ? 1'b0 : 1'bz;
    assign scl      = scl_q;
    assign done     = done_q;
    assign readData = rdata_q;

endmodule

// File: tb/tb_i2c_master.sv
// Bench for i2c_master: a bus-level slave decodes START/STOP/bytes/ACKs and compares them with
// a transaction-level model of the expected bus traffic, completion time and readData.
module tb_i2c_master;
    localparam int CLK_DIV = 2;
`ifdef I2C_MASTER_ACK_CHECK_EN
    localparam bit ACK_CHECK = 1'b1;
`else
    localparam bit ACK_CHECK = 1'b0;
`endif
    localparam int EV_START = 32'h100;
    localparam int EV_STOP  = 32'h101;
    localparam int EV_ACK   = 32'h200;

    logic       clk;
    logic       rst;
    logic       rw;
    logic [6:0] devAddr;
    logic [7:0] devInnerAddr;
    logic [7:0] sendData;
    logic [7:0] readData;
    logic       done;
    logic       scl;
    wire        sda;

    logic       slave_low;
    logic [7:0] rd_byte;
    logic       nack_first;

    int ncomp = 0;
    int nfail = 0;
    int ev_q[$];
    int exp_q[$];

    i2c_master #(.CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .rst(rst), .rw(rw), .devAddr(devAddr), .devInnerAddr(devInnerAddr),
        .sendData(sendData), .readData(readData), .done(done), .scl(scl), .sda(sda)
    );

    pullup (sda);
    assign sda = (slave_low && !rst) ? 1'b0 : 1'bz;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bus-level slave and protocol decoder, sampled midway between master clock edges.
    logic       pscl, psda, in_rd, rd_pend;
    logic [7:0] sh;
    int         bitcnt, byteidx, nbytes;
    always @(negedge clk) begin
        if (rst) begin
            ev_q.delete();
            bitcnt = 0; byteidx = 0; nbytes = 0;
            in_rd = 1'b0; rd_pend = 1'b0; slave_low = 1'b0; sh = 8'h00;
        end else if (pscl && scl && psda && !sda) begin
            ev_q.push_back(EV_START);
            bitcnt = 0; byteidx = 0; in_rd = 1'b0; rd_pend = 1'b0;
        end else if (pscl && scl && !psda && sda) begin
            ev_q.push_back(EV_STOP);
            bitcnt = 0; in_rd = 1'b0;
        end else if (!pscl && scl) begin
            if (bitcnt < 8) begin
                sh = {sh[6:0], sda};
                bitcnt++;
                if (bitcnt == 8) begin
                    ev_q.push_back(int'(sh));
                    if (byteidx == 0 && sh[0]) rd_pend = 1'b1;
                end
            end else begin
                ev_q.push_back(EV_ACK | int'(sda));
                bitcnt = 0; byteidx++; nbytes++;
                in_rd = rd_pend; rd_pend = 1'b0;
            end
        end else if (pscl && !scl) begin
            if (in_rd) slave_low = (bitcnt < 8) ? ~rd_byte[3'(7 - bitcnt)] : 1'b0;
            else       slave_low = (bitcnt == 8) && !(nack_first && nbytes == 0);
        end
        pscl = scl;
        psda = sda;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ncomp++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Transaction-level reference: bus events, bit-period count and final readData.
    task automatic build_exp(input bit r, input bit [6:0] a, input bit [7:0] ra, input bit [7:0] d,
                             input bit [7:0] rb, input bit nack1,
                             output int periods, output bit [7:0] exp_rd);
        int nb;
        exp_q.delete();
        exp_q.push_back(EV_START);
        exp_q.push_back(int'({a, 1'b0}));
        exp_q.push_back(EV_ACK | int'(nack1));
        nb = 1;
        exp_rd = 8'h00;
        if (ACK_CHECK && nack1) begin
            exp_rd = 8'hFF;
        end else begin
            exp_q.push_back(int'(ra));
            exp_q.push_back(EV_ACK);
            nb++;
            if (!r) begin
                exp_q.push_back(int'(d));
                exp_q.push_back(EV_ACK);
                nb++;
            end else begin
                exp_q.push_back(EV_START);
                exp_q.push_back(int'({a, 1'b1}));
                exp_q.push_back(EV_ACK);
                exp_q.push_back(int'(rb));
                exp_q.push_back(EV_ACK | 1);
                nb += 2;
                exp_rd = rb;
            end
        end
        exp_q.push_back(EV_STOP);
        periods = 2 + 9 * nb + ((r && !(ACK_CHECK && nack1)) ? 1 : 0);
    endtask

    task automatic start_txn(input bit r, input bit [6:0] a, input bit [7:0] ra, input bit [7:0] d,
                             input bit [7:0] rb, input bit nack1);
        rw = r; devAddr = a; devInnerAddr = ra; sendData = d;
        rd_byte = rb; nack_first = nack1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
    endtask

    task automatic run_txn(input string tag, input bit r, input bit [6:0] a, input bit [7:0] ra,
                           input bit [7:0] d, input bit [7:0] rb, input bit nack1, input bit poke);
        int periods, n, lim;
        bit [7:0] exp_rd;
        build_exp(r, a, ra, d, rb, nack1, periods, exp_rd);
        start_txn(r, a, ra, d, rb, nack1);
        n = periods * 4 * CLK_DIV;
        if (poke) begin
            repeat (40) @(posedge clk);
            rw = ~r; devAddr = ~a; devInnerAddr = ~ra; sendData = ~d;
            n -= 40;
        end
        repeat (n - 1) @(posedge clk);
        #1 chk({tag, ".done_early"}, 32'(done), 32'd0);
        @(posedge clk);
        #1 chk({tag, ".done_on_time"}, 32'(done), 32'd1);
        chk({tag, ".n_events"}, ev_q.size(), exp_q.size());
        lim = (ev_q.size() < exp_q.size()) ? ev_q.size() : exp_q.size();
        for (int i = 0; i < lim; i++) chk($sformatf("%s.ev%0d", tag, i), ev_q[i], exp_q[i]);
        chk({tag, ".readData"}, 32'(readData), 32'(exp_rd));
        repeat (8) @(posedge clk);
        #1 chk({tag, ".done_hold"}, 32'(done), 32'd1);
        chk({tag, ".scl_idle"}, 32'(scl), 32'd1);
        chk({tag, ".sda_idle"}, 32'(sda), 32'd1);
    endtask

    initial begin
        rst = 1'b1; rw = 1'b0; devAddr = '0; devInnerAddr = '0; sendData = '0;
        rd_byte = 8'h00; nack_first = 1'b0;

        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("reset.scl", 32'(scl), 32'd1);
            chk("reset.sda", 32'(sda), 32'd1);
            chk("reset.done", 32'(done), 32'd0);
            chk("reset.readData", 32'(readData), 32'd0);
        end

        run_txn("write", 1'b0, 7'h40, 8'h01, 8'hBA, 8'h00, 1'b0, 1'b0);
        run_txn("read", 1'b1, 7'h40, 8'h01, 8'h00, 8'h5A, 1'b0, 1'b0);

        // Abort in bit 5 of the register byte (a 0 bit, so the master is pulling SDA low).
        start_txn(1'b0, 7'h40, 8'h01, 8'hBA, 8'h00, 1'b0);
        repeat (12 * 4 * CLK_DIV) @(posedge clk);
        #2 chk("abort.pre_scl", 32'(scl), 32'd0);
        chk("abort.pre_sda", 32'(sda), 32'd0);
        rst = 1'b1;
        #1 chk("abort.scl", 32'(scl), 32'd1);
        chk("abort.sda", 32'(sda), 32'd1);
        chk("abort.done", 32'(done), 32'd0);
        chk("abort.readData", 32'(readData), 32'd0);
        run_txn("after_abort", 1'b0, 7'h40, 8'h01, 8'hBA, 8'h00, 1'b0, 1'b0);

        run_txn("addr_nack", 1'b0, 7'h40, 8'h01, 8'hBA, 8'h00, 1'b1, 1'b0);
        run_txn("late_change", 1'b0, 7'h40, 8'h01, 8'hBA, 8'h00, 1'b0, 1'b1);

        for (int k = 0; k < 6; k++) begin
            bit r, n1;
            bit [6:0] a;
            bit [7:0] ra, d, rb;
            r  = 1'($urandom_range(0, 1));
            a  = 7'($urandom);
            ra = 8'($urandom);
            d  = 8'($urandom);
            rb = 8'($urandom);
            n1 = ($urandom_range(0, 3) == 0);
            run_txn($sformatf("rand%0d", k), r, a, ra, d, rb, n1, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end
endmodule
